// File: rtl/gbox_rx_align_ctrl.sv
// Gearbox rx word-alignment trainer: walks bitslip positions and delay taps until the
// deserialized word equals train_pattern. Optional GBOX_ALIGN_DPA_RESTART_EN adds one restart.
module gbox_rx_align_ctrl #(
  parameter int unsigned PAR_DWID   = 10,
  parameter int unsigned PAR_TWID   = 6,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned MATCH_CNT  = 4
) (
  input  logic                core_clk,
  input  logic                core_reset,
  input  logic                align_start,
  input  logic [PAR_DWID-1:0] train_pattern,
  input  logic [PAR_DWID-1:0] des_data_out,
  input  logic                des_data_valid,
  input  logic [PAR_TWID-1:0] dly_tap,
  output logic                bitslip_adj,
  output logic                dly_ld,
  output logic                dly_inc,
  output logic                dly_adj,
  output logic                align_busy,
  output logic                align_done,
  output logic                align_error,
  output logic [3:0]          slip_count
`ifdef GBOX_ALIGN_DPA_RESTART_EN
  ,
  output logic                dpa_restart
`endif
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSettle, StCheck, StSlip, StTap, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [3:0]  match_q, match_d;
  logic [4:0]  slip_q, slip_d;
  logic        bitslip_q, bitslip_d;
  logic        ld_q, ld_d;
  logic        adj_q, adj_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
  logic        dpa_q, dpa_d;
  logic        dpa_used_q, dpa_used_d;
`endif

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    ld_d      = 1'b0;
    adj_d     = 1'b0;
    done_d    = done_q;
    error_d   = error_q;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
    dpa_d      = 1'b0;
    dpa_used_d = dpa_used_q;
`endif
    case (state_q)
      StIdle, StDone, StError: begin
        if (align_start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          slip_d  = '0;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
          dpa_used_d = 1'b0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        ld_d     = 1'b1;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (des_data_valid) begin
          if (settle_q == 8'(SETTLE_CYC - 1)) begin
            settle_d = '0;
            match_d  = '0;
            state_d  = StCheck;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
      end
      StCheck: begin
        if (des_data_valid) begin
          if (des_data_out == train_pattern) begin
            if (match_q == 4'(MATCH_CNT - 1)) begin
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            state_d = StSlip;
          end
        end
      end
      StSlip: begin
        bitslip_d = 1'b1;
        slip_d    = slip_q + 5'd1;
        settle_d  = '0;
        state_d   = (slip_q + 5'd1 == 5'(PAR_DWID)) ? StTap : StSettle;
      end
      StTap: begin
        // The last slip is still settling; hold off the tap step to keep pulse spacing.
        if (settle_q != 8'(SETTLE_CYC)) begin
          if (des_data_valid) settle_d = settle_q + 8'd1;
        end else begin
          settle_d = '0;
          if (&dly_tap) begin
`ifdef GBOX_ALIGN_DPA_RESTART_EN
            if (!dpa_used_q) begin
              dpa_d      = 1'b1;
              dpa_used_d = 1'b1;
              slip_d     = '0;
              state_d    = StLoad;
            end else begin
              error_d = 1'b1;
              state_d = StError;
            end
`else
            error_d = 1'b1;
            state_d = StError;
`endif
          end else begin
            adj_d   = 1'b1;
            slip_d  = '0;
            state_d = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      ld_q      <= 1'b0;
      adj_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
      dpa_q      <= 1'b0;
      dpa_used_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      ld_q      <= ld_d;
      adj_q     <= adj_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
      dpa_q      <= dpa_d;
      dpa_used_q <= dpa_used_d;
`endif
    end
  end

  assign bitslip_adj = bitslip_q;
  assign dly_ld      = ld_q;
  assign dly_adj     = adj_q;
  assign dly_inc     = adj_q;
  assign align_done  = done_q;
  assign align_error = error_q;
  assign slip_count  = slip_q[3:0];
  assign align_busy  = !(state_q inside {StIdle, StDone, StError});
`ifdef GBOX_ALIGN_DPA_RESTART_EN
  assign dpa_restart = dpa_q;
`endif

endmodule

// File: tb/tb_gbox_rx_align_ctrl.sv
// Directed bench for gbox_rx_align_ctrl with a small tap/rotation model of the gearbox rx.
module tb_gbox_rx_align_ctrl;

  logic       core_clk = 1'b0;
  logic       core_reset = 1'b1;
  logic       align_start = 1'b0;
  logic [9:0] train_pattern = '0;
  logic [9:0] des_data_out = '0;
  logic       des_data_valid = 1'b1;
  logic [5:0] dly_tap = '0;
  logic       bitslip_adj, dly_ld, dly_inc, dly_adj;
  logic       align_busy, align_done, align_error;
  logic [3:0] slip_count;
`ifdef GBOX_ALIGN_DPA_RESTART_EN
  logic       dpa_restart;
`endif

  gbox_rx_align_ctrl #(
    .PAR_DWID(10), .PAR_TWID(6), .SETTLE_CYC(8), .MATCH_CNT(4)
  ) dut (
    .core_clk       (core_clk),
    .core_reset     (core_reset),
    .align_start    (align_start),
    .train_pattern  (train_pattern),
    .des_data_out   (des_data_out),
    .des_data_valid (des_data_valid),
    .dly_tap        (dly_tap),
    .bitslip_adj    (bitslip_adj),
    .dly_ld         (dly_ld),
    .dly_inc        (dly_inc),
    .dly_adj        (dly_adj),
    .align_busy     (align_busy),
    .align_done     (align_done),
    .align_error    (align_error),
    .slip_count     (slip_count)
`ifdef GBOX_ALIGN_DPA_RESTART_EN
    ,
    .dpa_restart    (dpa_restart)
`endif
  );

  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Gearbox rx model state
  int tap_m = 0, load_tap = 0, good_tap = -1, rot_m = 0;
  bit always_good = 1'b0, gate = 1'b0;
  // Pulse bookkeeping
  int n_slip = 0, n_ld = 0, n_adj = 0, n_dpa = 0, last_pulse = -1000, min_gap = 1000;
  int c0 = 0, lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] v, input int r);
    logic [9:0] t;
    t = v;
    for (int i = 0; i < r; i++) t = {t[8:0], t[9]};
    return t;
  endfunction

  task automatic drive_data();
    dly_tap = tap_m[5:0];
    des_data_out = (always_good || tap_m == good_tap) ? rotl(train_pattern, rot_m) : 10'h000;
  endtask

  task automatic clear_counts();
    n_slip = 0; n_ld = 0; n_adj = 0; n_dpa = 0; last_pulse = -1000; min_gap = 1000;
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
    cyc++;
    if (bitslip_adj || dly_ld || dly_adj) begin
      chk("pulse_exclusive", 32'(bitslip_adj) + 32'(dly_ld) + 32'(dly_adj), 1);
      chk("inc_tracks_adj", dly_inc, dly_adj);
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    if (bitslip_adj) begin
      n_slip++;
      rot_m = (rot_m + 9) % 10;
    end
    if (dly_ld) begin
      n_ld++;
      tap_m = load_tap;
    end
    if (dly_adj) begin
      n_adj++;
      chk("slip_cleared_on_tap", slip_count, 0);
      tap_m = tap_m + 1;
    end
`ifdef GBOX_ALIGN_DPA_RESTART_EN
    if (dpa_restart) n_dpa++;
`endif
    des_data_valid = gate ? ~des_data_valid : 1'b1;
    drive_data();
  endtask

  task automatic kick();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (align_busy && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk({tag, "_timeout"}, 0, 1);
    lat = cyc - c0;
  endtask

  initial begin
    // Reset state
    drive_data();
    step(); step();
    core_reset = 1'b0;
    chk("rst_busy", align_busy, 0);
    chk("rst_done", align_done, 0);
    chk("rst_error", align_error, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_pulses", {bitslip_adj, dly_ld, dly_adj, dly_inc}, 0);

    // Aligned at start: 1 (load) + 8 settle + 4 match edges
    train_pattern = 10'h2AA; always_good = 1'b1; rot_m = 0; load_tap = 10;
    drive_data(); clear_counts();
    kick();
    chk("aligned_busy", align_busy, 1);
    wait_idle("aligned", 200);
    chk("aligned_latency", lat, 13);
    chk("aligned_done", align_done, 1);
    chk("aligned_ld", n_ld, 1);
    chk("aligned_slips", n_slip, 0);
    chk("aligned_slip_count", slip_count, 0);

    // Start while busy is ignored
    clear_counts();
    kick();
    chk("restart_clears_done", align_done, 0);
    step(); step(); step();
    align_start = 1'b1; step(); align_start = 1'b0;
    wait_idle("busy_start", 200);
    chk("busy_start_latency", lat, 13);
    chk("busy_start_ld", n_ld, 1);

    // Gated valid: every other word valid, lock latency roughly doubles
    gate = 1'b1; des_data_valid = 1'b1; clear_counts();
    kick();
    wait_idle("gated", 400);
    chk("gated_latency", lat, 24);
    chk("gated_done", align_done, 1);
    gate = 1'b0; des_data_valid = 1'b1;

    // Three-bit misalignment
    train_pattern = 10'h1C5; rot_m = 3; drive_data(); clear_counts();
    kick();
    wait_idle("misalign", 1000);
    chk("misalign_slips", n_slip, 3);
    chk("misalign_gap_ok", min_gap >= 9, 1);
    chk("misalign_done", align_done, 1);
    chk("misalign_slip_count", slip_count, 3);

    // Tap step: only tap 6 carries the pattern
    always_good = 1'b0; load_tap = 5; good_tap = 6; rot_m = 0; drive_data(); clear_counts();
    kick();
    wait_idle("tapstep", 2000);
    chk("tapstep_slips", n_slip, 10);
    chk("tapstep_adj", n_adj, 1);
    chk("tapstep_tap", tap_m, 6);
    chk("tapstep_gap_ok", min_gap >= 9, 1);
    chk("tapstep_done", align_done, 1);
    chk("tapstep_slip_count", slip_count, 0);

    // Exhaustion at the top tap, pattern never seen
    load_tap = 63; good_tap = -1; drive_data(); clear_counts();
    kick();
    wait_idle("exhaust", 3000);
    chk("exhaust_error", align_error, 1);
    chk("exhaust_done", align_done, 0);
    chk("exhaust_busy", align_busy, 0);
    chk("exhaust_adj", n_adj, 0);
`ifdef GBOX_ALIGN_DPA_RESTART_EN
    chk("exhaust_dpa", n_dpa, 1);
    chk("exhaust_ld", n_ld, 2);
    chk("exhaust_slips", n_slip, 20);
`else
    chk("exhaust_ld", n_ld, 1);
    chk("exhaust_slips", n_slip, 10);
    chk("exhaust_slip_count", slip_count, 10);
`endif

    // Reset mid-SETTLE aborts with no further pulses
    always_good = 1'b1; train_pattern = 10'h2AA; rot_m = 0; load_tap = 10;
    drive_data(); clear_counts();
    kick();
    chk("rst_restart_clears_error", align_error, 0);
    step(); step(); step(); step();
    chk("mid_settle_busy", align_busy, 1);
    core_reset = 1'b1; step(); core_reset = 1'b0;
    chk("midrst_busy", align_busy, 0);
    chk("midrst_outputs", {align_done, align_error, bitslip_adj, dly_ld, dly_adj}, 0);
    chk("midrst_slip_count", slip_count, 0);
    clear_counts();
    for (int i = 0; i < 30; i++) step();
    chk("midrst_no_pulses", n_ld + n_slip + n_adj, 0);
    chk("midrst_idle", {align_busy, align_done}, 0);
    kick();
    wait_idle("after_rst", 200);
    chk("after_rst_latency", lat, 13);
    chk("after_rst_done", align_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
